acc_rmw_ctrl: RTL
=================

# acc_rmw_ctrl

Read-modify-write initiator for the accumulator scratchpad. It accepts a stream of signed partial sums from the systolic array and issues reads and writes to the accumulator memory so that each targeted word becomes `old + partial`, or is overwritten on a first pass. It runs at one update per cycle, forwards in-flight results to hide the memory's read/write latency, and signals completion of a programmed batch.

## Interface
Parameters:
- `IN_WIDTH`, 16: width of the signed partial-sum input.
- `DATA_WIDTH`, 32: width of a signed accumulator word; must be ≥ `IN_WIDTH`.
- `ADDR_WIDTH`, 12: accumulator address width.
- `CNT_WIDTH`, 16: width of the batch length field.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a batch; honoured only in IDLE.
- `num_updates` in CNT_WIDTH: batch length, sampled on `start`.
- `in_valid` in 1: partial sum present.
- `in_ready` out 1: block can accept this cycle.
- `in_addr` in ADDR_WIDTH: target word.
- `in_data` in IN_WIDTH: signed partial sum.
- `in_first` in 1: overwrite the word instead of accumulating.
- `mem_read_req` out 1, `mem_read_addr` out ADDR_WIDTH: memory read port.
- `mem_read_data` in DATA_WIDTH: read data, valid 1 cycle after the request.
- `mem_write_req` out 1, `mem_write_addr` out ADDR_WIDTH, `mem_write_data` out DATA_WIDTH: memory write port.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a batch.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start` if `num_updates` ≠ 0.
  - IDLE → stays IDLE and pulses `done` the next cycle if `start` arrives with `num_updates` = 0.
  - RUN → DRAIN when the last accept occurs.
  - DRAIN → IDLE when the pipeline is empty; `done` pulses in the first IDLE cycle.
- `start` is ignored outside IDLE.
- `in_ready` = (state == RUN) && (remaining > 0). There is no backpressure from memory.
- Accept = `in_valid && in_ready`; each accept decrements `remaining`.
- Pipeline stages:
  - S1 (registered accept): issue `mem_read_req` unless `in_first` is set.
  - S2: compute `sum = in_first ? sext(in_data) : base + sext(in_data)`.
  - S3: registered write.
- `base` selection, youngest source first:
  - S3 write register, if its address matches (the op one cycle older);
  - last-committed register, if its address matches (the op two cycles older);
  - otherwise `mem_read_data`.
- Arithmetic is DATA_WIDTH two's complement and wraps modulo 2^DATA_WIDTH unless saturation is compiled in (see Configuration).
- Memory model: a write commits at the end of its cycle. A read that coincides with a write to the same address returns the old data, which is why the two-deep forwarding is required.

## Timing
- Accept at edge T:
  - `mem_read_req` high in cycle T+1;
  - data sampled in cycle T+2;
  - `mem_write_req` high in cycle T+3.
- Add-to-write latency is 3 cycles; throughput is 1 update per cycle.
- DRAIN lasts until S1–S3 are empty: 3 cycles after the last accept. `done` is asserted in cycle last-accept+4.
- Reset values: `in_ready`, `mem_read_req`, `mem_write_req`, `busy` and `done` are 0. All address and data outputs are 0. The state is IDLE and `remaining` is 0.
- Reset mid-batch: all in-flight ops are dropped and no write is issued in any cycle after the reset edge. Memory contents are not modified by this block.
- A read request holds its address stable for exactly one cycle. Write address and data are registered, with no combinational path from inputs.

## Configuration
- `ACC_RMW_SATURATE_EN`:
  - Defined: `sum` clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] on overflow.
  - Undefined: `sum` wraps. Timing is identical in both builds.

## Structure
- Shared package `acc_pkg`:
  - FSM state enum (IDLE/RUN/DRAIN);
  - a pipeline-stage struct (valid, addr, data, first);
  - the default width constants.
- One sub-module, `acc_sat_add`: a sign-extending adder with optional saturation under `ACC_RMW_SATURATE_EN`.

## Test plan
- Accumulate: memory[5] = 10, batch of 1, addr 5, data 7, first = 0 → one write of 17 to addr 5; `done` 4 cycles after the accept.
- Overwrite: memory[5] = 10, data −3, first = 1 → `mem_read_req` never asserted; addr 5 receives 0xFFFFFFFD.
- Hazard: memory[9] = 0, 4 back-to-back updates to addr 9 with data 1, 2, 3, 4 → writes 1, 3, 6, 10 on consecutive cycles.
- Interleaved hazard: sequence A, B, A with A = addr 1, B = addr 2, data 5 each, memory zeroed → addr 1 ends at 10 (tests the two-cycle-old forwarding).
- Overflow: memory[0] = 0x7FFFFFFF, data +1 → 0x7FFFFFFF with `ACC_RMW_SATURATE_EN`, 0x80000000 without it.
- Reset mid-batch: assert reset 1 cycle after an accept → no `mem_write_req` afterward; `busy`/`in_ready` are 0 and `start` works again.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulator read-modify-write block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_pkg;

  // Default widths; the pipeline-stage struct is sized from these.
  localparam int ACC_IN_WIDTH   = 16;
  localparam int ACC_DATA_WIDTH = 32;
  localparam int ACC_ADDR_WIDTH = 12;
  localparam int ACC_CNT_WIDTH  = 16;

  // Batch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One in-flight update. data holds the partial sum already sign-extended
  // to accumulator width.
  typedef struct packed {
    logic                      valid;
    logic [ACC_ADDR_WIDTH-1:0] addr;
    logic [ACC_DATA_WIDTH-1:0] data;
    logic                      first;
  } stage_t;

endpackage

// File: rtl/acc_sat_add.sv
// Sign-extending accumulator adder: sum = overwrite ? sext(addend) : base + sext(addend).
// Latency: combinational. Backpressure: none.
// Build option ACC_RMW_SATURATE_EN: clamp to the signed DATA_WIDTH range instead of wrapping.
module acc_sat_add #(
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [IN_WIDTH-1:0]   addend,
  input  logic                  overwrite,
  output logic [DATA_WIDTH-1:0] sum
);

`ifdef ACC_RMW_SATURATE_EN
  // One guard bit: overflow shows up as the top two bits disagreeing.
  logic [DATA_WIDTH:0] addend_x;
  logic [DATA_WIDTH:0] wide;

  // Saturating add; the guard bit's sign picks which rail to clamp to.
  always_comb begin
    addend_x = (DATA_WIDTH+1)'($signed(addend));
    wide     = {base[DATA_WIDTH-1], base} + addend_x;
    sum      = wide[DATA_WIDTH-1:0];
    if (overwrite) begin
      sum = addend_x[DATA_WIDTH-1:0];
    end else if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      if (wide[DATA_WIDTH]) begin
        sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  logic [DATA_WIDTH-1:0] addend_x;

  // Plain two's complement add, wrapping modulo 2^DATA_WIDTH.
  always_comb begin
    addend_x = DATA_WIDTH'($signed(addend));
    sum      = overwrite ? addend_x : base + addend_x;
  end
`endif

endmodule

// File: rtl/acc_rmw_ctrl.sv
// Read-modify-write initiator: each accepted partial sum turns mem[addr] into old+partial (or partial on first pass).
// Latency: accept edge T -> read in cycle T+1, add in T+2, write in T+3; one update per cycle, done at last accept+4.
// Backpressure: in_ready only while RUN with updates remaining; memory never stalls. Build option ACC_RMW_SATURATE_EN saturates.
module acc_rmw_ctrl
  import acc_pkg::*;
#(
  parameter int IN_WIDTH   = ACC_IN_WIDTH,
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
  parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_updates,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_first,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_req,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic                  accept;

  // S1 holds the op whose read is on the bus; S2 holds the op being added.
  stage_t                s1_q, s2_q;
  logic [ADDR_WIDTH-1:0] s2_addr;

  // S3: the registered write port.
  logic                  w_vld_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;

  // Last write that went out, kept one more cycle because a read issued in
  // the same cycle as that write saw the pre-write memory contents.
  logic                  lc_vld_q;
  logic [ADDR_WIDTH-1:0] lc_addr_q;
  logic [DATA_WIDTH-1:0] lc_data_q;

  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] sum;

  assign in_ready = (state_q == ST_RUN) && (remaining_q != '0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  assign mem_read_req   = s1_q.valid && !s1_q.first;
  assign mem_read_addr  = ADDR_WIDTH'(s1_q.addr);
  assign s2_addr        = ADDR_WIDTH'(s2_q.addr);

  assign mem_write_req  = w_vld_q;
  assign mem_write_addr = w_addr_q;
  assign mem_write_data = w_data_q;

  // Controller state, batch counter and the done pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Next state: zero-length batches complete immediately; DRAIN ends when
  // only the final write remains, so done lands on the first IDLE cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_updates == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_RUN;
            remaining_d = num_updates;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_q.valid && !s2_q.valid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // S1/S2 shift register; idle slots are zeroed so the read address rests at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (accept) begin
        s1_q.valid <= 1'b1;
        s1_q.addr  <= ACC_ADDR_WIDTH'(in_addr);
        s1_q.data  <= ACC_DATA_WIDTH'($signed(in_data));
        s1_q.first <= in_first;
      end else begin
        s1_q <= '0;
      end
      s2_q <= s1_q;
    end
  end

  // Base operand: the op one cycle older (S3) wins over the one two cycles
  // older (last committed), which wins over the stale memory read.
  always_comb begin
    base = mem_read_data;
    if (w_vld_q && (w_addr_q == s2_addr)) begin
      base = w_data_q;
    end else if (lc_vld_q && (lc_addr_q == s2_addr)) begin
      base = lc_data_q;
    end
  end

  acc_sat_add #(
    .IN_WIDTH   (DATA_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_add (
    .base      (base),
    .addend    (DATA_WIDTH'(s2_q.data)),
    .overwrite (s2_q.first),
    .sum       (sum)
  );

  // S3 write register and the last-committed copy behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_vld_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      lc_vld_q  <= 1'b0;
      lc_addr_q <= '0;
      lc_data_q <= '0;
    end else begin
      w_vld_q <= s2_q.valid;
      if (s2_q.valid) begin
        w_addr_q <= s2_addr;
        w_data_q <= sum;
      end
      lc_vld_q  <= w_vld_q;
      lc_addr_q <= w_addr_q;
      lc_data_q <= w_data_q;
    end
  end

endmodule
